// File: rtl/load_unit.sv
// load_unit: multi-cycle load engine for the P7 memory stage.
// Ports: clk, reset (sync, active-high); request side req/addr/load_type/flush;
//   DM read side mem_rd/mem_addr/mem_rvalid/mem_rdata;
//   result side busy/done/rdata/exc/exc_code/bad_addr (all registered).
module load_unit #(
    parameter logic [31:0] DM_BASE  = 32'h0000_0000,
    parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF,
    parameter int unsigned TIMEOUT  = 15
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [2:0]  load_type,
    input  logic        flush,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc,
    output logic [4:0]  exc_code,
    output logic [31:0] bad_addr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt;
    logic [31:0]     r_addr;
    logic [2:0]      r_type;
    logic            r_mem_rd;
    logic [31:0]     r_mem_addr;
    logic            r_busy;
    logic            r_done;
    logic [31:0]     r_rdata;
    logic            r_exc;
    logic [4:0]      r_exc_code;
    logic [31:0]     r_bad_addr;

    logic            w_cap;
    logic            w_rd;
    logic            w_done;
    logic            w_exc;
    logic [4:0]      w_code;
    logic [31:0]     w_bad;
    logic [31:0]     w_rdata;
    logic            w_is_w;
    logic            w_is_h;
    logic            w_misal;
    logic            w_oor;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ext;

    // Alignment / range checks act on the live request inputs.
    always_comb begin
        w_is_w  = (load_type == 3'd0) || (load_type > 3'd4);
        w_is_h  = (load_type == 3'd3) || (load_type == 3'd4);
        w_misal = (w_is_w && (addr[1:0] != 2'b00))
                || (w_is_h && addr[0]);
        // Wrapping subtract folds the lower-bound test into one compare.
        w_oor   = (addr - DM_BASE) > (DM_LIMIT - DM_BASE);
    end

    always_comb begin
        w_byte = mem_rdata[8*r_addr[1:0] +: 8];
        w_half = mem_rdata[16*r_addr[1] +: 16];
        unique case (r_type)
            3'd1:    w_ext = {{24{w_byte[7]}}, w_byte};
            3'd2:    w_ext = {24'h0, w_byte};
            3'd3:    w_ext = {{16{w_half[15]}}, w_half};
            3'd4:    w_ext = {16'h0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_next  = r_state;
        w_cnt   = r_cnt;
        w_cap   = 1'b0;
        w_rd    = 1'b0;
        w_done  = 1'b0;
        w_exc   = 1'b0;
        w_code  = 5'd0;
        w_bad   = 32'h0;
        w_rdata = r_rdata;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_cap = 1'b1;
                    if (w_misal || w_oor) begin
                        w_next  = S_DONE;
                        w_done  = 1'b1;
                        w_exc   = 1'b1;
                        w_code  = 5'd4;
                        w_bad   = addr;
                        w_rdata = 32'h0;
                    end else begin
                        w_next = S_WAIT;
                        w_rd   = 1'b1;
                        w_cnt  = '0;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_next  = S_DONE;
                    w_done  = 1'b1;
                    w_rdata = w_ext;
                end else if (r_cnt == TO_MAX) begin
                    w_next  = S_DONE;
                    w_done  = 1'b1;
                    w_exc   = 1'b1;
                    w_code  = 5'd7;
                    w_bad   = r_addr;
                    w_rdata = 32'h0;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Flush beats every other input and suppresses any result.
        if (flush) begin
            w_next  = S_IDLE;
            w_cap   = 1'b0;
            w_rd    = 1'b0;
            w_done  = 1'b0;
            w_exc   = 1'b0;
            w_code  = 5'd0;
            w_bad   = 32'h0;
            w_rdata = r_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= 32'h0;
            r_type     <= 3'd0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= 32'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= 32'h0;
            r_exc      <= 1'b0;
            r_exc_code <= 5'd0;
            r_bad_addr <= 32'h0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt;
            r_mem_rd   <= w_rd;
            r_busy     <= (w_next != S_IDLE);
            r_done     <= w_done;
            r_rdata    <= w_rdata;
            r_exc      <= w_exc;
            r_exc_code <= w_code;
            r_bad_addr <= w_bad;
            if (w_cap) begin
                r_addr     <= addr;
                r_type     <= load_type;
                r_mem_addr <= {addr[31:2], 2'b00};
            end
        end
    end

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign exc      = r_exc;
    assign exc_code = r_exc_code;
    assign bad_addr = r_bad_addr;

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: table vectors, corner sequences and random loads
// checked against a spec-level model of load_unit.
module tb_load_unit;

    localparam int TO = 15;
    localparam logic [31:0] LIMIT = 32'h0000_2FFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  load_type;
    logic        flush;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  exc_code;
    logic [31:0] bad_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_unit #(
        .DM_BASE (32'h0000_0000),
        .DM_LIMIT(LIMIT),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .addr      (addr),
        .load_type (load_type),
        .flush     (flush),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .exc       (exc),
        .exc_code  (exc_code),
        .bad_addr  (bad_addr)
    );

    typedef struct {
        logic [31:0] a;
        logic [2:0]  t;
        int          lat;
        logic [31:0] d;
        logic [31:0] r;
        logic        e;
        logic [4:0]  c;
        int          cyc;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: result of one load from the spec's rules.
    // DM_BASE is 0, so only the upper bound can be violated.
    task automatic model(input logic [31:0] a, input logic [2:0] t,
                         input int lat, input logic [31:0] d,
                         output logic [31:0] r, output logic e,
                         output logic [4:0] c, output int cyc);
        bit is_w, is_h, is_b;
        logic [31:0] v;
        int off;
        is_w = (t == 0) || (t > 4);
        is_h = (t == 3) || (t == 4);
        is_b = (t == 1) || (t == 2);
        off  = int'(a % 4);
        if ((is_w && off != 0) || (is_h && (a % 2) != 0)
            || a > LIMIT) begin
            r = 32'h0; e = 1'b1; c = 5'd4; cyc = 1;
        end else if (lat >= 0 && lat <= TO) begin
            e = 1'b0; c = 5'd0; cyc = 2 + lat;
            if (is_b) begin
                v = (d >> (8 * off)) & 32'hFF;
                if (t == 1 && v >= 32'd128) v = v - 32'd256;
            end else if (is_h) begin
                v = (d >> (8 * off)) & 32'hFFFF;
                if (t == 3 && v >= 32'd32768) v = v - 32'd65536;
            end else begin
                v = d;
            end
            r = v;
        end else begin
            r = 32'h0; e = 1'b1; c = 5'd7; cyc = TO + 2;
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge, idle.
    task automatic run_load(input string nm, input logic [31:0] a,
                            input logic [2:0] t, input int lat,
                            input logic [31:0] d,
                            input logic [31:0] xr, input logic xe,
                            input logic [4:0] xc, input int xcyc);
        int cyc = -1;
        int nrd = 0;
        bit busy_ok = 1'b1;
        logic [31:0] rd_addr = 32'hX;
        logic [31:0] g_r, g_b;
        logic g_e;
        logic [4:0] g_c;
        req = 1'b1; addr = a; load_type = t; mem_rdata = d;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (mem_rd === 1'b1) begin
                nrd++;
                rd_addr = mem_addr;
            end
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
            mem_rvalid = (c == 1 + lat);
        end
        mem_rvalid = 1'b0;
        g_r = rdata; g_e = exc; g_c = exc_code; g_b = bad_addr;
        check({nm, " done_cycle"}, 32'(cyc), 32'(xcyc));
        check({nm, " exc"}, {31'h0, g_e}, {31'h0, xe});
        check({nm, " exc_code"}, {27'h0, g_c}, {27'h0, xc});
        check({nm, " bad_addr"}, g_b, xe ? a : 32'h0);
        check({nm, " busy"}, {31'h0, busy_ok}, 32'h1);
        if (xc == 5'd4) begin
            check({nm, " mem_rd_count"}, 32'(nrd), 32'd0);
        end else begin
            check({nm, " rdata"}, g_r, xr);
            check({nm, " mem_rd_count"}, 32'(nrd), 32'd1);
            check({nm, " mem_addr"}, rd_addr, {a[31:2], 2'b00});
        end
        @(negedge clk);
        check({nm, " idle_after"}, {30'h0, busy, done}, 32'h0);
    endtask

    initial begin
        logic [31:0] er, ra, rd;
        logic ee;
        logic [4:0] ec;
        logic [2:0] rt;
        int ecyc, rl;
        bit seen;

        tbl[0]  = '{32'h13, 3'd1, 1, 32'h80FF_1234,
                    32'hFFFF_FF80, 1'b0, 5'd0, 3};
        tbl[1]  = '{32'h13, 3'd2, 1, 32'h80FF_1234,
                    32'h0000_0080, 1'b0, 5'd0, 3};
        tbl[2]  = '{32'h22, 3'd3, 0, 32'h8001_7FFF,
                    32'hFFFF_8001, 1'b0, 5'd0, 2};
        tbl[3]  = '{32'h22, 3'd4, 0, 32'h8001_7FFF,
                    32'h0000_8001, 1'b0, 5'd0, 2};
        tbl[4]  = '{32'h20, 3'd3, 0, 32'h8001_7FFF,
                    32'h0000_7FFF, 1'b0, 5'd0, 2};
        tbl[5]  = '{32'h06, 3'd0, 0, 32'h0,
                    32'h0, 1'b1, 5'd4, 1};
        tbl[6]  = '{32'h3000, 3'd0, 0, 32'h0,
                    32'h0, 1'b1, 5'd4, 1};
        tbl[7]  = '{32'h40, 3'd0, -1, 32'h5555_5555,
                    32'h0, 1'b1, 5'd7, 17};
        tbl[8]  = '{32'h21, 3'd4, 0, 32'h0,
                    32'h0, 1'b1, 5'd4, 1};
        tbl[9]  = '{32'h2FFC, 3'd0, 3, 32'hDEAD_BEEF,
                    32'hDEAD_BEEF, 1'b0, 5'd0, 5};
        tbl[10] = '{32'h2FFF, 3'd1, 15, 32'h7F00_0000,
                    32'h0000_007F, 1'b0, 5'd0, 17};
        tbl[11] = '{32'h104, 3'd7, 2, 32'h1234_5678,
                    32'h1234_5678, 1'b0, 5'd0, 4};

        reset = 1'b1; req = 1'b0; addr = 32'h0; load_type = 3'd0;
        flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_state",
              {mem_rd, busy, done, exc, 27'h0, exc_code},
              32'h0);
        check("reset_data", rdata | bad_addr | mem_addr, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_load($sformatf("vec%0d", i), tbl[i].a, tbl[i].t,
                     tbl[i].lat, tbl[i].d, tbl[i].r, tbl[i].e,
                     tbl[i].c, tbl[i].cyc);
        end

        // Flush in the second WAIT cycle, stale rvalid right after.
        seen = 1'b0;
        req = 1'b1; addr = 32'h80; load_type = 3'd0;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk); req = 1'b0;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush_busy_drop", {31'h0, busy}, 32'h0);
        if (done === 1'b1) seen = 1'b1;
        mem_rvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("flush_no_done", {31'h0, seen}, 32'h0);
        run_load("after_flush", 32'h84, 3'd0, 1, 32'h0BAD_F00D,
                 32'h0BAD_F00D, 1'b0, 5'd0, 3);

        // Reset in WAIT clears everything.
        req = 1'b1; addr = 32'h13; load_type = 3'd1;
        mem_rdata = 32'h80FF_1234;
        @(negedge clk); req = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("wait_reset_ctl",
              {mem_rd, busy, done, exc, 27'h0, exc_code},
              32'h0);
        check("wait_reset_data", rdata | bad_addr | mem_addr, 32'h0);
        run_load("after_reset", 32'h13, 3'd1, 1, 32'h80FF_1234,
                 32'hFFFF_FF80, 1'b0, 5'd0, 3);

        // Random loads against the model.
        for (int n = 0; n < 150; n++) begin
            rt = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) ra = $urandom();
            else ra = 32'($urandom_range(0, 32'h3003));
            if ($urandom_range(0, 9) == 0) rl = -1;
            else rl = int'($urandom_range(0, TO + 2));
            rd = $urandom();
            model(ra, rt, rl, rd, er, ee, ec, ecyc);
            run_load($sformatf("rnd%0d", n), ra, rt, rl, rd,
                     er, ee, ec, ecyc);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
